// File: rtl/bsg_link_ddr_rx_deframer.sv
// -----------------------------------------------------------------------------
// bsg_link_ddr_rx_deframer
//
// Receive-side deframer for a DDR source-synchronous link. Each clk_i it takes
// the double-width word produced by the IDDR capture stage:
//   data_i[cw-1:0]     posedge half, bit cw-1 = valid, rest = payload
//   data_i[2cw-1:cw]   negedge half, bit 2cw-1 = valid, rest = payload
// It strips the valid flags and pushes up to two payloads per cycle into a
// FIFO in arrival order (posedge half first). The consumer pops the FIFO with
// valid_o/yumi_i. Every dequeue frees one transmitter credit. Credits go back
// as a toggle on token_o, once per 2**lg_credit_to_token_decimation_p
// dequeues.
//
// Ports:
//   clk_i       link clock
//   reset_i     synchronous active-high reset
//   data_i      {negedge half, posedge half}
//   valid_o     FIFO head valid
//   data_o      FIFO head payload
//   yumi_i      consumer takes the head this cycle (only while valid_o)
//   token_o     credit-return toggle
//   overflow_o  sticky: a valid half was dropped for lack of space
//   rx_count_o  count of written entries, saturating (stats build only)
//
// Optional feature:
//   BSG_LINK_RX_STATS_EN  defined   -> rx_count_o counter is built
//                         undefined -> rx_count_o is tied to 0, no flops
// -----------------------------------------------------------------------------
module bsg_link_ddr_rx_deframer #(
    parameter int channel_width_p                 = 32,
    parameter int lg_fifo_depth_p                 = 3,
    parameter int lg_credit_to_token_decimation_p = 2
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic [2*channel_width_p-1:0]   data_i,
    output logic                           valid_o,
    output logic [channel_width_p-2:0]     data_o,
    input  logic                           yumi_i,
    output logic                           token_o,
    output logic                           overflow_o,
    output logic [15:0]                    rx_count_o
);

    localparam int cw_lp    = channel_width_p;
    localparam int pw_lp    = channel_width_p - 1;
    localparam int lg_lp    = lg_fifo_depth_p;
    localparam int depth_lp = 1 << lg_fifo_depth_p;
    localparam int lgd_lp   = lg_credit_to_token_decimation_p;

    localparam logic [lg_lp:0] depth_c = {1'b1, {lg_lp{1'b0}}};

    logic [pw_lp-1:0] mem_r [depth_lp];
    logic [lg_lp-1:0] wr_ptr_r;
    logic [lg_lp-1:0] rd_ptr_r;
    logic [lg_lp:0]   occ_r;
    logic             valid_r;
    logic             token_r;
    logic             overflow_r;

    logic             v_p_s;
    logic             v_n_s;
    logic [pw_lp-1:0] pay_p_s;
    logic [pw_lp-1:0] pay_n_s;
    logic [1:0]       nv_s;
    logic [lg_lp:0]   free_s;
    logic [1:0]       wr_cnt_s;
    logic [pw_lp-1:0] wr0_pay_s;
    logic             drop_s;
    logic             deq_s;
    logic             wrap_s;
    logic [lg_lp:0]   occ_next_s;
    logic [lg_lp-1:0] wr_ptr_p1_s;

    assign v_p_s       = data_i[cw_lp-1];
    assign v_n_s       = data_i[2*cw_lp-1];
    assign pay_p_s     = data_i[cw_lp-2:0];
    assign pay_n_s     = data_i[2*cw_lp-2:cw_lp];
    assign nv_s        = {1'b0, v_p_s} + {1'b0, v_n_s};
    // Space is judged at cycle start; a same-cycle dequeue does not make room.
    assign free_s      = depth_c - occ_r;
    assign deq_s       = yumi_i & valid_r;
    assign wr_ptr_p1_s = wr_ptr_r + lg_lp'(1'b1);
    assign occ_next_s  = occ_r + (lg_lp+1)'(wr_cnt_s) - (lg_lp+1)'(deq_s);

    // Decide how many valid halves fit and which payload lands in the first slot.
    always_comb begin
        wr_cnt_s  = 2'd0;
        drop_s    = 1'b0;
        wr0_pay_s = v_p_s ? pay_p_s : pay_n_s;
        if (free_s >= (lg_lp+1)'(nv_s)) begin
            wr_cnt_s = nv_s;
            drop_s   = 1'b0;
        end else if (free_s == {(lg_lp+1){1'b0}}) begin
            wr_cnt_s = 2'd0;
            drop_s   = 1'b1;
        end else begin
            // Two valid halves, one free slot: keep the earlier (posedge) half.
            wr_cnt_s = 2'd1;
            drop_s   = 1'b1;
        end
    end

    // FIFO storage; no reset needed since pointers gate visibility.
    always_ff @(posedge clk_i) begin
        if (!reset_i && (wr_cnt_s != 2'd0)) begin
            mem_r[wr_ptr_r] <= wr0_pay_s;
        end
        if (!reset_i && (wr_cnt_s == 2'd2)) begin
            mem_r[wr_ptr_p1_s] <= pay_n_s;
        end
    end

    // Pointers, occupancy, head-valid, sticky overflow and token toggle.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_r   <= {lg_lp{1'b0}};
            rd_ptr_r   <= {lg_lp{1'b0}};
            occ_r      <= {(lg_lp+1){1'b0}};
            valid_r    <= 1'b0;
            overflow_r <= 1'b0;
            token_r    <= 1'b0;
        end else begin
            wr_ptr_r   <= wr_ptr_r + lg_lp'(wr_cnt_s);
            rd_ptr_r   <= rd_ptr_r + lg_lp'(deq_s);
            occ_r      <= occ_next_s;
            valid_r    <= (occ_next_s != {(lg_lp+1){1'b0}});
            overflow_r <= overflow_r | drop_s;
            token_r    <= token_r ^ (deq_s & wrap_s);
        end
    end

    generate
        if (lgd_lp == 0) begin : g_no_decimation
            assign wrap_s = 1'b1;
        end else begin : g_decimation
            logic [lgd_lp-1:0] dec_cnt_r;

            // Dequeue counter; the token toggles when it wraps back to 0.
            always_ff @(posedge clk_i) begin
                if (reset_i) begin
                    dec_cnt_r <= {lgd_lp{1'b0}};
                end else if (deq_s) begin
                    dec_cnt_r <= dec_cnt_r + lgd_lp'(1'b1);
                end else begin
                    dec_cnt_r <= dec_cnt_r;
                end
            end

            assign wrap_s = &dec_cnt_r;
        end
    endgenerate

`ifdef BSG_LINK_RX_STATS_EN
    logic [15:0] rx_count_r;
    logic [16:0] rx_sum_s;

    assign rx_sum_s = {1'b0, rx_count_r} + 17'(wr_cnt_s);

    // Saturating count of entries actually written into the FIFO.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rx_count_r <= 16'h0000;
        end else if (rx_sum_s[16]) begin
            rx_count_r <= 16'hFFFF;
        end else begin
            rx_count_r <= rx_sum_s[15:0];
        end
    end

    assign rx_count_o = rx_count_r;
`else
    assign rx_count_o = 16'h0000;
`endif

    assign valid_o    = valid_r;
    assign data_o     = mem_r[rd_ptr_r];
    assign token_o    = token_r;
    assign overflow_o = overflow_r;

endmodule

// File: tb/tb_bsg_link_ddr_rx_deframer.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for bsg_link_ddr_rx_deframer
// (cw=32, depth=8, decimation=2). Inputs are driven and outputs sampled 1 time
// unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_bsg_link_ddr_rx_deframer;

    logic        clk_i;
    logic        reset_i;
    logic [63:0] data_i;
    logic        valid_o;
    logic [30:0] data_o;
    logic        yumi_i;
    logic        token_o;
    logic        overflow_o;
    logic [15:0] rx_count_o;

    int vectors;
    int miscompares;

    bsg_link_ddr_rx_deframer #(
        .channel_width_p                 (32),
        .lg_fifo_depth_p                 (3),
        .lg_credit_to_token_decimation_p (2)
    ) dut (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .data_i     (data_i),
        .valid_o    (valid_o),
        .data_o     (data_o),
        .yumi_i     (yumi_i),
        .token_o    (token_o),
        .overflow_o (overflow_o),
        .rx_count_o (rx_count_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic apply_reset();
        reset_i = 1'b1;
        data_i  = 64'h0;
        yumi_i  = 1'b0;
        step();
        step();
        reset_i = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        vectors++;
        if ({valid_o, token_o, overflow_o} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_flags got v/t/o=%b required 000", {valid_o, token_o, overflow_o});
        end
        vectors++;
        if (rx_count_o !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_rx_count got %h required 0000", rx_count_o);
        end
    endtask

    task automatic test_idle();
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            step();
            vectors++;
            if ({valid_o, token_o, overflow_o} !== 3'b000) begin
                miscompares++;
                $display("FAIL idle_%0d got v/t/o=%b required 000", i, {valid_o, token_o, overflow_o});
            end
        end
    endtask

    task automatic test_both_halves();
        apply_reset();
        data_i = {1'b1, 31'h0000_00BB, 1'b1, 31'h0000_00AA};
        step();
        data_i = 64'h0;
        vectors++;
        if (valid_o !== 1'b1 || data_o !== 31'h0000_00AA) begin
            miscompares++;
            $display("FAIL both_first got v=%b d=%h required v=1 d=000000aa", valid_o, data_o);
        end
        yumi_i = valid_o;
        step();
        vectors++;
        if (valid_o !== 1'b1 || data_o !== 31'h0000_00BB) begin
            miscompares++;
            $display("FAIL both_second got v=%b d=%h required v=1 d=000000bb", valid_o, data_o);
        end
        yumi_i = valid_o;
        step();
        yumi_i = 1'b0;
        vectors++;
        if (valid_o !== 1'b0 || token_o !== 1'b0) begin
            miscompares++;
            $display("FAIL both_empty got v=%b t=%b required v=0 t=0", valid_o, token_o);
        end
    endtask

    task automatic test_negedge_only();
        apply_reset();
        for (int k = 1; k <= 4; k++) begin
            // posedge half carries junk payload with valid=0; it must not be stored
            data_i = {1'b1, 31'(k), 1'b0, 31'h7FFF_FFFF};
            yumi_i = valid_o;
            step();
            vectors++;
            if (valid_o !== 1'b1 || data_o !== 31'(k) || token_o !== 1'b0) begin
                miscompares++;
                $display("FAIL negonly_%0d got v=%b d=%h t=%b required v=1 d=%h t=0",
                         k, valid_o, data_o, token_o, 31'(k));
            end
        end
        data_i = 64'h0;
        yumi_i = 1'b1;
        step();
        yumi_i = 1'b0;
        vectors++;
        if (valid_o !== 1'b0 || token_o !== 1'b1) begin
            miscompares++;
            $display("FAIL negonly_token got v=%b t=%b required v=0 t=1", valid_o, token_o);
        end
        step();
        vectors++;
        if (token_o !== 1'b1) begin
            miscompares++;
            $display("FAIL negonly_token_hold got t=%b required t=1", token_o);
        end
    endtask

    task automatic test_overflow_full();
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            data_i = {1'b1, 31'(16 + 2*i + 1), 1'b1, 31'(16 + 2*i)};
            step();
            vectors++;
            if (overflow_o !== 1'b0) begin
                miscompares++;
                $display("FAIL full_fill_%0d got ovf=%b required 0", i, overflow_o);
            end
        end
        data_i = {1'b1, 31'h0000_0066, 1'b1, 31'h0000_0055};
        step();
        data_i = 64'h0;
        vectors++;
        if (overflow_o !== 1'b1) begin
            miscompares++;
            $display("FAIL full_overflow got ovf=%b required 1", overflow_o);
        end
        for (int j = 0; j < 8; j++) begin
            vectors++;
            if (valid_o !== 1'b1 || data_o !== 31'(16 + j) || overflow_o !== 1'b1) begin
                miscompares++;
                $display("FAIL full_drain_%0d got v=%b d=%h ovf=%b required v=1 d=%h ovf=1",
                         j, valid_o, data_o, overflow_o, 31'(16 + j));
            end
            yumi_i = 1'b1;
            step();
        end
        yumi_i = 1'b0;
        vectors++;
        if (valid_o !== 1'b0 || overflow_o !== 1'b1) begin
            miscompares++;
            $display("FAIL full_empty got v=%b ovf=%b required v=0 ovf=1", valid_o, overflow_o);
        end
    endtask

    task automatic test_partial_drop();
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            data_i = {1'b1, 31'(32 + 2*i + 1), 1'b1, 31'(32 + 2*i)};
            step();
        end
        data_i = {1'b0, 31'h0000_0000, 1'b1, 31'h0000_0026};
        step();
        vectors++;
        if (overflow_o !== 1'b0 || data_o !== 31'h0000_0020) begin
            miscompares++;
            $display("FAIL partial_pre got ovf=%b d=%h required ovf=0 d=00000020", overflow_o, data_o);
        end
        // occupancy 7: posedge half fits, negedge half dropped, head dequeued
        data_i = {1'b1, 31'h0000_002F, 1'b1, 31'h0000_0027};
        yumi_i = 1'b1;
        step();
        data_i = 64'h0;
        vectors++;
        if (overflow_o !== 1'b1) begin
            miscompares++;
            $display("FAIL partial_overflow got ovf=%b required 1", overflow_o);
        end
        for (int j = 0; j < 7; j++) begin
            vectors++;
            if (valid_o !== 1'b1 || data_o !== 31'(33 + j)) begin
                miscompares++;
                $display("FAIL partial_drain_%0d got v=%b d=%h required v=1 d=%h",
                         j, valid_o, data_o, 31'(33 + j));
            end
            step();
        end
        yumi_i = 1'b0;
        vectors++;
        if (valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL partial_empty got v=%b required 0", valid_o);
        end
    endtask

    task automatic test_reset_midstream();
        logic [15:0] exp_count;
        apply_reset();
`ifdef BSG_LINK_RX_STATS_EN
        exp_count = 16'd5;
`else
        exp_count = 16'd0;
`endif
        data_i = {1'b1, 31'h0000_0041, 1'b1, 31'h0000_0040};
        step();
        data_i = {1'b1, 31'h0000_0043, 1'b1, 31'h0000_0042};
        step();
        data_i = {1'b0, 31'h0000_0000, 1'b1, 31'h0000_0044};
        step();
        data_i = 64'h0;
        vectors++;
        if (valid_o !== 1'b1 || rx_count_o !== exp_count) begin
            miscompares++;
            $display("FAIL midreset_pre got v=%b cnt=%h required v=1 cnt=%h", valid_o, rx_count_o, exp_count);
        end
        // valid input during reset must be ignored
        reset_i = 1'b1;
        data_i  = {1'b1, 31'h0000_0077, 1'b1, 31'h0000_0076};
        step();
        reset_i = 1'b0;
        data_i  = 64'h0;
        vectors++;
        if ({valid_o, token_o, overflow_o} !== 3'b000 || rx_count_o !== 16'h0000) begin
            miscompares++;
            $display("FAIL midreset_post got v/t/o=%b cnt=%h required 000 cnt=0000",
                     {valid_o, token_o, overflow_o}, rx_count_o);
        end
        step();
        vectors++;
        if (valid_o !== 1'b0 || rx_count_o !== 16'h0000) begin
            miscompares++;
            $display("FAIL midreset_hold got v=%b cnt=%h required v=0 cnt=0000", valid_o, rx_count_o);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset_i     = 1'b1;
        data_i      = 64'h0;
        yumi_i      = 1'b0;
        test_reset();
        test_idle();
        test_both_halves();
        test_negedge_only();
        test_overflow_full();
        test_partial_drop();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
